vga_scan_ctrl: RTL and testbench

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

---
 rtl/vga_pkg.sv | 53 +++++
 rtl/vga_timing_cnt.sv | 46 ++++
 rtl/vga_scan_ctrl.sv | 115 +++++++++++
 tb/tb_vga_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pixel types and small helpers for the scan controller.
package vga_pkg;
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;

  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  localparam int IMG_W_D = 512;
  localparam int IMG_H_D = 480;

  localparam int CNT_W  = 10;
  localparam int ADDR_W = 19;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Per-pixel side info carried alongside the valid shift register.
  typedef struct packed {
    logic             in_img;
    logic             hs;
    logic             vs;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
  } stage_t;

  function automatic rgb888_t expand444(input rgb444_t p);
    rgb888_t o;
    o.r = {p.r, p.r};
    o.g = {p.g, p.g};
    o.b = {p.b, p.b};
    return o;
  endfunction

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction
endpackage

// File: rtl/vga_timing_cnt.sv
// Horizontal/vertical scan counters plus the stage-0 active and sync-pulse decode.
module vga_timing_cnt import vga_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hs_act,
  output logic             vs_act
);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic line_end;
  assign line_end = (h_cnt == H_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= line_end ? '0 : h_cnt + CNT_W'(1);
      if (line_end) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end
  end

  // Sync flags are active-high here; polarity is flipped only at the output register.
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_act = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_act = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: ROM address generation, 3-cycle pixel pipeline and colour output stage.
module vga_scan_ctrl import vga_pkg::*; #(
  parameter int          H_ACTIVE = H_ACTIVE_D,
  parameter int          H_FP     = H_FP_D,
  parameter int          H_SYNC   = H_SYNC_D,
  parameter int          H_BP     = H_BP_D,
  parameter int          V_ACTIVE = V_ACTIVE_D,
  parameter int          V_FP     = V_FP_D,
  parameter int          V_SYNC   = V_SYNC_D,
  parameter int          V_BP     = V_BP_D,
  parameter int          IMG_W    = IMG_W_D,
  parameter int          IMG_H    = IMG_H_D,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [11:0]       pixel_in,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [CNT_W-1:0]  h_addr,
  output logic [CNT_W-1:0]  v_addr,
  output logic              hsync,
  output logic              vsync,
  output logic              valid,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              frame_start
);
  localparam int STAGES = 2;
  localparam logic [CNT_W-1:0] IMG_W_C = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] IMG_H_C = CNT_W'(IMG_H);

  logic [CNT_W-1:0]  h_cnt, v_cnt;
  logic              active0, hs0, vs0, in_img0;
  logic [ADDR_W-1:0] addr0;

  vga_timing_cnt #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .active (active0),
    .hs_act (hs0),
    .vs_act (vs0)
  );

  assign in_img0 = (h_cnt < IMG_W_C) && (v_cnt < IMG_H_C);

  generate
    if (is_pow2(IMG_W)) begin : g_shift
      localparam int SH = $clog2(IMG_W);
      assign addr0 = (ADDR_W'(v_cnt) << SH) + ADDR_W'(h_cnt);
    end else begin : g_rowbase
      // row_base steps in lockstep with v_cnt so it always equals v_cnt*IMG_W.
      localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
      localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
      logic [ADDR_W-1:0] row_base;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) row_base <= '0;
        else if (h_cnt == H_LAST)
          row_base <= (v_cnt == V_LAST) ? '0 : row_base + ADDR_W'(IMG_W);
      end
      assign addr0 = row_base + ADDR_W'(h_cnt);
    end
  endgenerate

  stage_t            s0, s1, s2;
  logic [STAGES-1:0] vld_pipe;
  rgb888_t           pix;

  assign s0  = '{in_img: in_img0, hs: hs0, vs: vs0, h: h_cnt, v: v_cnt};
  assign pix = expand444(rgb444_t'(pixel_in));

  // Stage 1 issues the ROM address; stage 2 lines up with the ROM's registered data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      rom_addr <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], active0};
      s1       <= s0;
      s2       <= s1;
      if (in_img0) rom_addr <= addr0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid       <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      h_addr      <= '0;
      v_addr      <= '0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      valid       <= vld_pipe[STAGES-1];
      hsync       <= ~s2.hs;
      vsync       <= ~s2.vs;
      h_addr      <= vld_pipe[STAGES-1] ? s2.h : '0;
      v_addr      <= vld_pipe[STAGES-1] ? s2.v : '0;
      frame_start <= vld_pipe[STAGES-1] && (s2.h == '0) && (s2.v == '0);
      if (!vld_pipe[STAGES-1])  {vga_r, vga_g, vga_b} <= 24'h000000;
      else if (!s2.in_img)      {vga_r, vga_g, vga_b} <= BG_COLOR;
      else                      {vga_r, vga_g, vga_b} <= pix;
    end
  end
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: a default-timing instance plus a short-frame instance checked against a scan model.
module tb_vga_scan_ctrl;
  localparam logic [23:0] BG_S = 24'h2a5c93;
  localparam int SV_ACT = 8, SV_FP = 2, SV_SYNC = 2, SV_BP = 3, SIMG_H = 6;
  localparam int S_FRAME = 800 * (SV_ACT + SV_FP + SV_SYNC + SV_BP);

  typedef struct packed {
    logic        fs, vld, hs, vs;
    logic [9:0]  h, v;
    logic [23:0] rgb;
    logic [18:0] rom;
  } out_t;

  logic clk = 1'b0, reset = 1'b0;
  always #20 clk = ~clk;

  logic [11:0] pix_d = '0, pix_s = '0;
  logic [18:0] rom_d, rom_s;
  logic [9:0]  hx_d, vx_d, hx_s, vx_s;
  logic        hs_d, vs_d, vld_d, fs_d, hs_s, vs_s, vld_s, fs_s;
  logic [7:0]  r_d, g_d, b_d, r_s, g_s, b_s;
  out_t        act_d, act_s;

  vga_scan_ctrl dut_d (
    .clk(clk), .reset(reset), .pixel_in(pix_d), .rom_addr(rom_d),
    .h_addr(hx_d), .v_addr(vx_d), .hsync(hs_d), .vsync(vs_d), .valid(vld_d),
    .vga_r(r_d), .vga_g(g_d), .vga_b(b_d), .frame_start(fs_d));

  vga_scan_ctrl #(.V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
                  .IMG_H(SIMG_H), .BG_COLOR(BG_S)) dut_s (
    .clk(clk), .reset(reset), .pixel_in(pix_s), .rom_addr(rom_s),
    .h_addr(hx_s), .v_addr(vx_s), .hsync(hs_s), .vsync(vs_s), .valid(vld_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .frame_start(fs_s));

  // Image ROMs with registered address: data = low 12 address bits.
  always @(posedge clk) begin
    pix_d <= rom_d[11:0];
    pix_s <= rom_s[11:0];
  end

  assign act_d = {fs_d, vld_d, hs_d, vs_d, hx_d, vx_d, r_d, g_d, b_d, rom_d};
  assign act_s = {fs_s, vld_s, hs_s, vs_s, hx_s, vx_s, r_s, g_s, b_s, rom_s};

  int edges = 0;
  always @(posedge clk or negedge reset)
    if (!reset) edges <= 0;
    else        edges <= edges + 1;

  int n_cmp = 0, n_err = 0;

  // Expected outputs after clock edge n since reset release, from raster arithmetic.
  function automatic out_t model(input int n, input bit sm);
    int vt  = sm ? (SV_ACT + SV_FP + SV_SYNC + SV_BP) : 525;
    int va  = sm ? SV_ACT : 480;
    int vsb = sm ? (SV_ACT + SV_FP) : 490;
    int ih  = sm ? SIMG_H : 480;
    logic [23:0] bg = sm ? BG_S : 24'h000000;
    int c, h, v, a;
    logic [11:0] px;
    out_t e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (n >= 1) begin
      c = n - 1; h = c % 800; v = (c / 800) % vt;
      if (v >= ih)       a = (ih - 1) * 512 + 511;
      else if (h >= 512) a = v * 512 + 511;
      else               a = v * 512 + h;
      e.rom = 19'(a);
    end
    if (n >= 3) begin
      c = n - 3; h = c % 800; v = (c / 800) % vt;
      e.vld = (h < 640) && (v < va);
      e.hs  = !((h >= 656) && (h < 752));
      e.vs  = !((v >= vsb) && (v < vsb + 2));
      if (e.vld) begin
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.fs = (h == 0) && (v == 0);
        if ((h < 512) && (v < ih)) begin
          px    = 12'(v * 512 + h);
          e.rgb = {px[11:8], px[11:8], px[7:4], px[7:4], px[3:0], px[3:0]};
        end else begin
          e.rgb = bg;
        end
      end
    end
    return e;
  endfunction

  task automatic goto(input int n);
    int guard = 0;
    while (edges < n && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (edges != n) begin
      n_err++;
      $display("FAIL goto: edges=%0d required %0d", edges, n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_cmp += 3;
      if (act_d !== model(0, 0)) begin n_err++; $display("FAIL reset_d: got %h exp %h", act_d, model(0, 0)); end
      if (act_s !== model(0, 1)) begin n_err++; $display("FAIL reset_s: got %h exp %h", act_s, model(0, 1)); end
      if (!(hs_d === 1'b1 && vs_d === 1'b1)) begin
        n_err++; $display("FAIL reset_sync: hsync=%b vsync=%b exp 1 1", hs_d, vs_d);
      end
    end
  endtask

  // Called at a negedge with reset low.
  task automatic test_startup;
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp += 3;
      if (act_d !== model(edges, 0)) begin n_err++; $display("FAIL start_d k=%0d: got %h exp %h", k, act_d, model(edges, 0)); end
      if (act_s !== model(edges, 1)) begin n_err++; $display("FAIL start_s k=%0d: got %h exp %h", k, act_s, model(edges, 1)); end
      if (fs_d !== (k == 3)) begin n_err++; $display("FAIL start_fs k=%0d: got %b exp %b", k, fs_d, (k == 3)); end
      if (k == 3) begin
        n_cmp++;
        if (!(vld_d === 1'b1 && hx_d === 10'd0 && vx_d === 10'd0)) begin
          n_err++; $display("FAIL start_first: valid=%b h=%0d v=%0d exp 1 0 0", vld_d, hx_d, vx_d);
        end
      end
    end
  endtask

  task automatic test_pixel_405;
    goto(3 + 2 * 800 + 5);
    n_cmp += 3;
    if ({hx_d, vx_d} !== {10'd5, 10'd2}) begin n_err++; $display("FAIL px405_pos: h=%0d v=%0d exp 5 2", hx_d, vx_d); end
    if ({r_d, g_d, b_d} !== 24'h440055) begin n_err++; $display("FAIL px405_d: got %h exp 440055", {r_d, g_d, b_d}); end
    if ({r_s, g_s, b_s} !== 24'h440055) begin n_err++; $display("FAIL px405_s: got %h exp 440055", {r_s, g_s, b_s}); end
  endtask

  task automatic test_boundaries;
    int hl[10] = '{0, 511, 512, 639, 640, 655, 656, 751, 752, 799};
    for (int v = 5; v <= 12; v++) begin
      for (int i = 0; i < 10; i++) begin
        goto(3 + v * 800 + hl[i]);
        n_cmp += 2;
        if (act_d !== model(edges, 0)) begin n_err++; $display("FAIL bound_d v=%0d h=%0d: got %h exp %h", v, hl[i], act_d, model(edges, 0)); end
        if (act_s !== model(edges, 1)) begin n_err++; $display("FAIL bound_s v=%0d h=%0d: got %h exp %h", v, hl[i], act_s, model(edges, 1)); end
      end
    end
  endtask

  task automatic test_line_timing;
    int guard = 0, v_hi = 0, hs_lo = 0, hs_lo1 = 0, hs_first = -1, rise2 = -1;
    logic pv;
    do begin
      pv = vld_d;
      @(negedge clk);
      guard++;
    end while (!(!pv && vld_d) && guard < 2000);
    n_cmp++;
    if (guard >= 2000) begin n_err++; $display("FAIL line_wait: no valid rise in %0d clocks", guard); end
    for (int k = 0; k < 1600; k++) begin
      if (vld_d) v_hi++;
      if (!hs_d) begin
        hs_lo++;
        if (k < 800) hs_lo1++;
        if (hs_first < 0) hs_first = k;
      end
      if (k > 0 && !pv && vld_d && rise2 < 0) rise2 = k;
      pv = vld_d;
      @(negedge clk);
    end
    n_cmp += 5;
    if (rise2 != 800)    begin n_err++; $display("FAIL line_period: got %0d exp 800", rise2); end
    if (v_hi != 1280)    begin n_err++; $display("FAIL line_valid: got %0d exp 1280", v_hi); end
    if (hs_lo1 != 96)    begin n_err++; $display("FAIL line_hsync_len: got %0d exp 96", hs_lo1); end
    if (hs_lo != 192)    begin n_err++; $display("FAIL line_hsync_2l: got %0d exp 192", hs_lo); end
    if (hs_first != 656) begin n_err++; $display("FAIL line_hsync_ofs: got %0d exp 656", hs_first); end
  endtask

  task automatic test_random(input int reps);
    for (int i = 0; i < reps; i++) begin
      goto(edges + int'($urandom_range(1, 300)));
      n_cmp += 2;
      if (act_d !== model(edges, 0)) begin n_err++; $display("FAIL rand_d n=%0d: got %h exp %h", edges, act_d, model(edges, 0)); end
      if (act_s !== model(edges, 1)) begin n_err++; $display("FAIL rand_s n=%0d: got %h exp %h", edges, act_s, model(edges, 1)); end
    end
  endtask

  task automatic test_frame_timing;
    int guard = 0, t0, lines = 0, vs_low = 0, period = -1;
    logic phs;
    while (!fs_s && guard < S_FRAME + 10) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (!fs_s) begin n_err++; $display("FAIL frame_wait: no frame_start in %0d clocks", guard); end
    t0  = edges;
    phs = hs_s;
    for (int k = 1; k <= S_FRAME + 100 && period < 0; k++) begin
      @(negedge clk);
      if (phs && !hs_s) lines++;
      phs = hs_s;
      if (!vs_s) vs_low++;
      if (fs_s) period = edges - t0;
    end
    n_cmp += 3;
    if (period != S_FRAME) begin n_err++; $display("FAIL frame_period: got %0d exp %0d", period, S_FRAME); end
    if (lines != 15)       begin n_err++; $display("FAIL frame_lines: got %0d exp 15", lines); end
    if (vs_low != 1600)    begin n_err++; $display("FAIL frame_vsync: got %0d exp 1600", vs_low); end
  endtask

  task automatic test_mid_frame_reset;
    int n = edges + ((4300 - (edges % S_FRAME) + S_FRAME) % S_FRAME);
    if (n <= edges) n += S_FRAME;
    goto(n);
    #5 reset = 1'b0;
    #1;
    n_cmp += 2;
    if (act_d !== model(0, 0)) begin n_err++; $display("FAIL midrst_async_d: got %h exp %h", act_d, model(0, 0)); end
    if (act_s !== model(0, 1)) begin n_err++; $display("FAIL midrst_async_s: got %h exp %h", act_s, model(0, 1)); end
    repeat (5) begin
      @(posedge clk);
      #1;
      n_cmp += 2;
      if (act_d !== model(0, 0)) begin n_err++; $display("FAIL midrst_hold_d: got %h exp %h", act_d, model(0, 0)); end
      if (act_s !== model(0, 1)) begin n_err++; $display("FAIL midrst_hold_s: got %h exp %h", act_s, model(0, 1)); end
    end
    @(negedge clk);
    test_startup();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_pixel_405();
    test_boundaries();
    test_line_timing();
    test_random(40);
    test_frame_timing();
    test_mid_frame_reset();
    test_random(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
